aer_spike_sender: RTL and testbench



---
 rtl/aer_pkg.sv | 25 ++
 rtl/sync_ff.sv | 29 ++
 rtl/aer_spike_sender.sv | 153 +++++++++++++++
 tb/tb_aer_spike_sender.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aer_pkg.sv
// Shared definitions for the AER event senders.
//   sender_state_e  : handshake FSM state encoding
//   PFX_*           : event-type prefix codes placed in the top AER address bits
//   aer_addr_width  : address width = prefix + index field
package aer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETUP    = 2'd1,
      ST_REQ_HIGH = 2'd2,
      ST_REQ_LOW  = 2'd3
   } sender_state_e;

   localparam int AER_PREFIX_W = 2;

   // Event-type prefixes; neuron and config codes are reserved for the other senders
   localparam logic [AER_PREFIX_W-1:0] PFX_NEURON      = 2'b00;
   localparam logic [AER_PREFIX_W-1:0] PFX_INPUT_SPIKE = 2'b01;
   localparam logic [AER_PREFIX_W-1:0] PFX_CONFIG      = 2'b10;

   function automatic int aer_addr_width(input int prefix_bits, input int image_size_bits);
      return prefix_bits + image_size_bits + 1;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for asynchronous inputs.
//   CLK, RST : destination clock, synchronous active-high reset (flops clear to 0)
//   D        : asynchronous input
//   Q        : D after STAGES flops
module sync_ff #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);

   logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      sync_d[0] = D;
      for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
   end

   always_ff @(posedge CLK) begin
      if (RST) sync_q <= '0;
      else     sync_q <= sync_d;
   end

   assign Q = sync_q[STAGES-1];

endmodule

// File: rtl/aer_spike_sender.sv
// Turns each sorted pixel index into one input-spike event on the AER bus
// using a 4-phase REQ/ACK handshake, and back-pressures the sorter with BUSY.
//   CLK, RST          : clock, synchronous active-high reset
//   NEXT_INDEX        : pixel index, valid while FOUND_NEXT_INDEX is high
//   FOUND_NEXT_INDEX  : 1-cycle strobe from the sorter
//   NEW_IMAGE         : clears SPIKE_COUNT and the error flags
//   AERIN_CTRL_BUSY   : high while an event is in flight
//   AERIN_ADDR        : {EVENT_PREFIX, index}, held after the event
//   AERIN_REQ/ACK     : handshake; ACK is asynchronous
//   SPIKE_COUNT       : completed handshakes since last clear, saturating
//   ERR_TIMEOUT       : sticky, a handshake phase ran out of time
//   ERR_OVERRUN       : sticky, a strobe arrived while busy
module aer_spike_sender
   import aer_pkg::*;
#(
   parameter int                      IMAGE_SIZE      = 256,
   parameter int                      IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
   parameter int                      PREFIX_BITS     = AER_PREFIX_W,
   parameter logic [PREFIX_BITS-1:0]  EVENT_PREFIX    = PFX_INPUT_SPIKE,
   parameter int                      AER_ADDR_W      = aer_addr_width(PREFIX_BITS, IMAGE_SIZE_BITS),
   parameter int                      SYNC_STAGES     = 2,
   parameter int                      ACK_TIMEOUT     = 255
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [IMAGE_SIZE_BITS:0]   NEXT_INDEX,
   input  logic                       FOUND_NEXT_INDEX,
   input  logic                       NEW_IMAGE,
   output logic                       AERIN_CTRL_BUSY,
   output logic [AER_ADDR_W-1:0]      AERIN_ADDR,
   output logic                       AERIN_REQ,
   input  logic                       AERIN_ACK,
   output logic [IMAGE_SIZE_BITS:0]   SPIKE_COUNT,
   output logic                       ERR_TIMEOUT,
   output logic                       ERR_OVERRUN
);

   // Timeout counter only needs to reach ACK_TIMEOUT-1
   localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam bit TO_EN = (ACK_TIMEOUT > 0);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

   sender_state_e              state_q, state_d;
   logic                       req_q, req_d;
   logic                       busy_q, busy_d;
   logic [AER_ADDR_W-1:0]      addr_q, addr_d;
   logic [IMAGE_SIZE_BITS:0]   cnt_q, cnt_d;
   logic                       err_to_q, err_to_d;
   logic                       err_ov_q, err_ov_d;
   logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
   logic                       ack_s;

   sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_ack_sync (
      .CLK (CLK),
      .RST (RST),
      .D   (AERIN_ACK),
      .Q   (ack_s)
   );

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      busy_d   = busy_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      err_to_d = err_to_q;
      err_ov_d = err_ov_q;
      to_cnt_d = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (FOUND_NEXT_INDEX) begin
               addr_d  = {EVENT_PREFIX, NEXT_INDEX};
               busy_d  = 1'b1;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            // A stale ACK (e.g. after reset mid-handshake) must clear first
            if (!ack_s) begin
               req_d   = 1'b1;
               state_d = ST_REQ_HIGH;
            end
         end
         ST_REQ_HIGH: begin
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = ST_REQ_LOW;
            end
         end
         ST_REQ_LOW: begin
            if (!ack_s) begin
               busy_d  = 1'b0;
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Phase timer: counts cycles spent in the current busy state; progress
      // in the same cycle as expiry takes priority.
      if (TO_EN && state_q != ST_IDLE && state_d == state_q) begin
         if (to_cnt_q == TO_LAST) begin
            req_d    = 1'b0;
            busy_d   = 1'b0;
            err_to_d = 1'b1;
            state_d  = ST_IDLE;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end

      if (FOUND_NEXT_INDEX && state_q != ST_IDLE) err_ov_d = 1'b1;

      // Clear overrides any increment or error set in the same cycle
      if (NEW_IMAGE) begin
         cnt_d    = '0;
         err_to_d = 1'b0;
         err_ov_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         req_q    <= 1'b0;
         busy_q   <= 1'b0;
         addr_q   <= '0;
         cnt_q    <= '0;
         err_to_q <= 1'b0;
         err_ov_q <= 1'b0;
         to_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         busy_q   <= busy_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         err_to_q <= err_to_d;
         err_ov_q <= err_ov_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   assign AERIN_CTRL_BUSY = busy_q;
   assign AERIN_REQ       = req_q;
   assign AERIN_ADDR      = addr_q;
   assign SPIKE_COUNT     = cnt_q;
   assign ERR_TIMEOUT     = err_to_q;
   assign ERR_OVERRUN     = err_ov_q;

endmodule

// File: tb/tb_aer_spike_sender.sv
module tb_aer_spike_sender;

   localparam int SS = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   // main DUT (default timeout)
   logic [8:0]  idx = '0;
   logic        fnd = 1'b0, newimg = 1'b0;
   logic        busy, req;
   logic [10:0] addr;
   logic [8:0]  cnt;
   logic        eto, eov;
   logic        ack_in, ack_auto = 1'b0, ack_man = 1'b0;
   bit          rcv_auto = 1'b1;

   // timeout DUT: receiver never acks
   logic [8:0]  idx2 = '0;
   logic        fnd2 = 1'b0, new2 = 1'b0, ack2 = 1'b0;
   logic        busy2, req2;
   logic [10:0] addr2;
   logic [8:0]  cnt2;
   logic        eto2, eov2;

   int          n_chk = 0, n_err = 0;
   logic [8:0]  exp_q[$];
   int          rcv_dly = 4;
   int          hs_cnt = 0;

   assign ack_in = rcv_auto ? ack_auto : ack_man;

   aer_spike_sender u_dut (
      .CLK(clk), .RST(rst), .NEXT_INDEX(idx), .FOUND_NEXT_INDEX(fnd), .NEW_IMAGE(newimg),
      .AERIN_CTRL_BUSY(busy), .AERIN_ADDR(addr), .AERIN_REQ(req), .AERIN_ACK(ack_in),
      .SPIKE_COUNT(cnt), .ERR_TIMEOUT(eto), .ERR_OVERRUN(eov)
   );

   aer_spike_sender #(.ACK_TIMEOUT(8)) u_dut_to (
      .CLK(clk), .RST(rst), .NEXT_INDEX(idx2), .FOUND_NEXT_INDEX(fnd2), .NEW_IMAGE(new2),
      .AERIN_CTRL_BUSY(busy2), .AERIN_ADDR(addr2), .AERIN_REQ(req2), .AERIN_ACK(ack2),
      .SPIKE_COUNT(cnt2), .ERR_TIMEOUT(eto2), .ERR_OVERRUN(eov2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int enc(input logic [8:0] i);
      logic [10:0] a;
      a = {2'b01, i};
      return int'(a);
   endfunction

   // Auto receiver: pops the scoreboard on each new REQ and checks the address
   // both at REQ rise and one cycle earlier.
   initial begin
      int rs = 0;
      int rc = 0;
      logic [10:0] addr_prev = '0;
      logic [8:0]  e;
      forever begin
         @(negedge clk);
         if (!rcv_auto) begin
            rs = 0;
         end else begin
            case (rs)
               0: if (req && !ack_auto) begin
                     chk("q_size_at_req", exp_q.size(), 1);
                     if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("addr_before_req", int'(addr_prev), enc(e));
                        chk("addr_at_req", int'(addr), enc(e));
                     end
                     rc = rcv_dly; rs = 1;
                  end
               1: if (rc <= 1) begin ack_auto = 1'b1; rs = 2; end else rc--;
               2: if (!req) begin rc = rcv_dly; rs = 3; end
               3: if (rc <= 1) begin ack_auto = 1'b0; hs_cnt++; rs = 0; end else rc--;
               default: rs = 0;
            endcase
         end
         addr_prev = addr;
      end
   end

   task automatic strobe(input logic [8:0] i, input bit push, input bit with_new);
      @(negedge clk);
      idx = i; fnd = 1'b1; newimg = with_new;
      if (push) exp_q.push_back(i);
      @(negedge clk);
      fnd = 1'b0; newimg = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 2000) begin @(negedge clk); n++; end
      chk(tag, int'(busy), 0);
   endtask

   task automatic wait_req(input logic lvl, input string tag);
      int n = 0;
      while (req !== lvl && n < 100) begin @(negedge clk); n++; end
      chk(tag, int'(req), int'(lvl));
   endtask

   task automatic pulse_new();
      @(negedge clk); newimg = 1'b1;
      @(negedge clk); newimg = 1'b0;
   endtask

   int inten[256];
   int pos[256];

   initial begin
      int n;
      bit seen_req;
      int hs0;

      // ---- reset ----
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_req", int'(req), 0);
      chk("rst_addr", int'(addr), 0);
      chk("rst_cnt", int'(cnt), 0);
      chk("rst_eto", int'(eto), 0);
      chk("rst_eov", int'(eov), 0);

      // ---- basic event, index 37 ----
      strobe(9'd37, 1'b1, 1'b0);
      chk("basic_busy_after_strobe", int'(busy), 1);
      n = 0; seen_req = 1'b0;
      while (busy && n < 200) begin
         if (req) seen_req = 1'b1;
         @(negedge clk); n++;
      end
      chk("basic_req_seen", int'(seen_req), 1);
      chk("basic_busy_low", int'(busy), 0);
      chk("basic_req_low", int'(req), 0);
      chk("basic_addr_hold", int'(addr), 11'b01_000100101);
      chk("basic_cnt", int'(cnt), 1);
      chk("basic_hs", hs_cnt, 1);
      chk("basic_eto", int'(eto), 0);
      chk("basic_eov", int'(eov), 0);

      // ---- overrun: index 5 strobed while REQ is high for index 9 ----
      strobe(9'd9, 1'b1, 1'b0);
      wait_req(1'b1, "ovr_req_high");
      strobe(9'd5, 1'b0, 1'b0);
      wait_idle("ovr_idle");
      repeat (30) @(negedge clk);
      chk("ovr_busy_stays_low", int'(busy), 0);
      chk("ovr_eov", int'(eov), 1);
      chk("ovr_addr", int'(addr), enc(9'd9));
      chk("ovr_hs", hs_cnt, 2);
      chk("ovr_cnt", int'(cnt), 2);
      pulse_new();
      chk("ovr_clr_cnt", int'(cnt), 0);
      chk("ovr_clr_eov", int'(eov), 0);

      // ---- 256-pixel image through a sorter model ----
      for (int i = 0; i < 256; i++) inten[i] = i;
      for (int i = 255; i > 0; i--) begin
         int j, t;
         j = $urandom_range(i, 0);
         t = inten[i]; inten[i] = inten[j]; inten[j] = t;
      end
      for (int i = 0; i < 256; i++) pos[inten[i]] = i;
      rcv_dly = 1;
      hs0 = hs_cnt;
      for (int r = 0; r < 256; r++) begin
         strobe(9'(pos[255 - r]), 1'b1, 1'b0);
         n = 0;
         while (busy && n < 200) begin @(negedge clk); n++; end
         if (busy) chk("img_idle", int'(busy), 0);
      end
      chk("img_hs", hs_cnt - hs0, 256);
      chk("img_cnt", int'(cnt), 256);
      chk("img_eov", int'(eov), 0);
      chk("img_q_empty", exp_q.size(), 0);

      // ---- NEW_IMAGE with a strobe, then NEW_IMAGE with a completion ----
      strobe(9'd100, 1'b1, 1'b1);
      wait_idle("nw_idle0");
      chk("nw_with_strobe_cnt", int'(cnt), 1);
      strobe(9'd101, 1'b1, 1'b0); wait_idle("nw_idle1");
      strobe(9'd102, 1'b1, 1'b0); wait_idle("nw_idle2");
      chk("nw_cnt3", int'(cnt), 3);
      rcv_auto = 1'b0; ack_man = 1'b0;
      strobe(9'd20, 1'b0, 1'b0);
      wait_req(1'b1, "nw_req_high");
      ack_man = 1'b1;
      wait_req(1'b0, "nw_req_low");
      @(negedge clk);
      ack_man = 1'b0;
      repeat (SS) @(negedge clk);
      chk("nw_busy_before_done", int'(busy), 1);
      newimg = 1'b1;
      @(negedge clk);
      newimg = 1'b0;
      chk("nw_done_busy", int'(busy), 0);
      chk("nw_done_cnt", int'(cnt), 0);

      // ---- timeout on the never-acking DUT ----
      @(negedge clk); idx2 = 9'd3; fnd2 = 1'b1;
      @(negedge clk); fnd2 = 1'b0;
      chk("to_busy", int'(busy2), 1);
      n = 0;
      while (!req2 && n < 20) begin @(negedge clk); n++; end
      chk("to_req_rise", int'(req2), 1);
      n = 0;
      while (req2 && n < 50) begin @(negedge clk); n++; end
      chk("to_req_cycles", n, 8);
      chk("to_busy_low", int'(busy2), 0);
      chk("to_eto", int'(eto2), 1);
      chk("to_cnt", int'(cnt2), 0);
      @(negedge clk); new2 = 1'b1;
      @(negedge clk); new2 = 1'b0;
      chk("to_clr_eto", int'(eto2), 0);

      // ---- reset mid-handshake with ACK held high ----
      strobe(9'd7, 1'b0, 1'b0);
      wait_req(1'b1, "rh_req_high");
      ack_man = 1'b1;
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("rh_req_after_rst", int'(req), 0);
      chk("rh_busy_after_rst", int'(busy), 0);
      rst = 1'b0;
      repeat (SS) @(negedge clk);
      strobe(9'd12, 1'b0, 1'b0);
      chk("rh_setup_busy", int'(busy), 1);
      chk("rh_setup_req0", int'(req), 0);
      @(negedge clk);
      chk("rh_setup_req1", int'(req), 0);
      ack_man = 1'b0;
      n = 0;
      while (!req && n < 20) begin @(negedge clk); n++; end
      chk("rh_req_delay", n, SS + 1);
      chk("rh_addr", int'(addr), enc(9'd12));
      ack_man = 1'b1;
      wait_req(1'b0, "rh_req_low");
      ack_man = 1'b0;
      wait_idle("rh_idle");
      chk("rh_cnt", int'(cnt), 1);
      chk("rh_eto", int'(eto), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
